fetch_unit: RTL and testbench

//  Instruction fetch stage: owns the PC, drives icache read requests, and feeds the
//  IF/ID pipeline register (instruction, fetch address, enable_IF_ID, flush_IF_ID).

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/fetch_skid_buf.sv | 38 +++
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the fetch-stage state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN,
        BUFFERED,
        HALTED
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instruction} holding register for an icache hit that lands during a stall.
module fetch_skid_buf
    import cpu_types_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  load_i,
    input  logic  clear_i,
    input  word_t pc_i,
    input  word_t instr_i,
    output logic  valid_o,
    output word_t pc_o,
    output word_t instr_o
);

    logic  valid_q;
    word_t pc_q;
    word_t instr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, icache requests, IF/ID write/flush control, halt and redirect.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  iREN,
    output word_t imemaddr,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_addr,
    input  logic  halt,
    output word_t instruction,
    output word_t pc_IF_ID,
    output logic  enable_IF_ID,
    output logic  flush_IF_ID
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        target;
    logic         buf_load, buf_clear, buf_valid;
    word_t        buf_pc, buf_instr;

    assign target   = {redirect_addr[31:2], 2'b00};
    assign imemaddr = pc_q;

    fetch_skid_buf u_skid (
        .clk_i   (CLK),
        .rst_i   (RST),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .pc_i    (pc_q),
        .instr_i (imemload),
        .valid_o (buf_valid),
        .pc_o    (buf_pc),
        .instr_o (buf_instr)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            pc_q    <= PC_INIT;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (redirect) begin
                    pc_d = target;
                end else if (ihit) begin
                    pc_d = pc_q + PC_STEP;
                    if (stall) state_d = BUFFERED;
                end
            end
            BUFFERED: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (redirect) begin
                    pc_d    = target;
                    state_d = RUN;
                end else if (!stall) begin
                    state_d = RUN;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = HALTED;
        endcase
    end

    always_comb begin
        iREN         = 1'b0;
        enable_IF_ID = 1'b0;
        flush_IF_ID  = 1'b0;
        instruction  = '0;
        pc_IF_ID     = '0;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;
        if (RST) begin
            flush_IF_ID = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    iREN = 1'b1;
                    if (halt || redirect) begin
                        flush_IF_ID = 1'b1;
                    end else if (stall) begin
                        buf_load = ihit;
                    end else if (ihit) begin
                        enable_IF_ID = 1'b1;
                        instruction  = imemload;
                        pc_IF_ID     = pc_q;
                    end else begin
                        // Miss: bubble rather than re-latching a stale word.
                        flush_IF_ID = 1'b1;
                    end
                end
                BUFFERED: begin
                    if (halt || redirect) begin
                        flush_IF_ID = 1'b1;
                        buf_clear   = 1'b1;
                    end else if (!stall) begin
                        enable_IF_ID = buf_valid;
                        flush_IF_ID  = !buf_valid;
                        instruction  = buf_valid ? buf_instr : '0;
                        pc_IF_ID     = buf_valid ? buf_pc : '0;
                        buf_clear    = 1'b1;
                    end
                end
                default: flush_IF_ID = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Vector/scoreboard bench for fetch_unit: reset, streaming, miss, skid buffer, redirect, halt.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST, ihit, stall, redirect, halt;
    logic [31:0] imemload, redirect_addr;
    logic        iREN, enable_IF_ID, flush_IF_ID;
    logic [31:0] imemaddr, instruction, pc_IF_ID;

    fetch_unit #(.PC_INIT(32'h0)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .ihit          (ihit),
        .imemload      (imemload),
        .iREN          (iREN),
        .imemaddr      (imemaddr),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt          (halt),
        .instruction   (instruction),
        .pc_IF_ID      (pc_IF_ID),
        .enable_IF_ID  (enable_IF_ID),
        .flush_IF_ID   (flush_IF_ID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, ihit, stall, redir, halt;
        logic [31:0] load, raddr;
        logic        chk_addr, iren, en, fl;
        logic [31:0] addr, instr, pcid;
    } vec_t;

    vec_t vecs[$];
    vec_t expq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic rst, logic hit, logic [31:0] load, logic stl, logic rd,
                                logic [31:0] ra, logic hlt, logic ca, logic iren,
                                logic [31:0] addr, logic en, logic fl, logic [31:0] instr,
                                logic [31:0] pcid);
        vec_t v;
        v.rst = rst; v.ihit = hit; v.load = load; v.stall = stl; v.redir = rd;
        v.raddr = ra; v.halt = hlt; v.chk_addr = ca; v.iren = iren; v.addr = addr;
        v.en = en; v.fl = fl; v.instr = instr; v.pcid = pcid;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        vec_t e;
        RST = v.rst; ihit = v.ihit; imemload = v.load; stall = v.stall;
        redirect = v.redir; redirect_addr = v.raddr; halt = v.halt;
        expq.push_back(v);
        @(negedge CLK);
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL step %0d scoreboard: got empty queue expected entry", idx);
        end else begin
            e = expq.pop_front();
            check("iREN", idx, {31'b0, iREN}, {31'b0, e.iren});
            check("enable", idx, {31'b0, enable_IF_ID}, {31'b0, e.en});
            check("flush", idx, {31'b0, flush_IF_ID}, {31'b0, e.fl});
            check("instruction", idx, instruction, e.instr);
            check("pc_IF_ID", idx, pc_IF_ID, e.pcid);
            if (e.chk_addr) check("imemaddr", idx, imemaddr, e.addr);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //                 rst hit load          stl rd raddr         hlt ca iren addr          en fl instr         pcid
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 1, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 32'hAAAA_0001, 0, 0, 32'h0,       0, 1, 1, 32'h0,        1, 0, 32'hAAAA_0001, 32'h0));
        vecs.push_back(mk(0, 1, 32'hBBBB_0002, 0, 0, 32'h0,       0, 1, 1, 32'h4,        1, 0, 32'hBBBB_0002, 32'h4));
        vecs.push_back(mk(0, 1, 32'hCCCC_0003, 0, 0, 32'h0,       0, 1, 1, 32'h8,        1, 0, 32'hCCCC_0003, 32'h8));
        vecs.push_back(mk(0, 1, 32'hDDDD_0004, 0, 0, 32'h0,       0, 1, 1, 32'hC,        1, 0, 32'hDDDD_0004, 32'hC));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 32'h5555,  0, 0, 32'h0,       0, 1, 1, 32'h10,       0, 1, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 32'hEEEE_0005, 0, 0, 32'h0,       0, 1, 1, 32'h10,       1, 0, 32'hEEEE_0005, 32'h10));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 1, 32'h100 + i, 0, 0, 32'h0,     0, 1, 1, 32'h14 + 4 * i, 1, 0, 32'h100 + i, 32'h14 + 4 * i));
        // Stall + hit at 0x20 parks X in the skid buffer, delivered once stall drops.
        vecs.push_back(mk(0, 1, 32'h1234_5678, 1, 0, 32'h0,       0, 1, 1, 32'h20,       0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 32'hDEAD_0000, 1, 0, 32'h0,       0, 1, 0, 32'h24,       0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 32'hDEAD_0001, 1, 0, 32'h0,       0, 1, 0, 32'h24,       0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 32'hDEAD_0002, 0, 0, 32'h0,       0, 1, 0, 32'h24,       1, 0, 32'h1234_5678, 32'h20));
        vecs.push_back(mk(0, 1, 32'hBAD0_0001, 0, 1, 32'h103,     0, 1, 1, 32'h24,       0, 1, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 1, 32'h100,      0, 1, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 32'h7777_0007, 1, 0, 32'h0,       0, 1, 1, 32'h100,      0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h200,      0, 1, 0, 32'h104,      0, 1, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 32'h2222_0200, 0, 0, 32'h0,       0, 1, 1, 32'h200,      1, 0, 32'h2222_0200, 32'h200));
        vecs.push_back(mk(0, 1, 32'hBAD0_0002, 0, 1, 32'h300,     1, 1, 1, 32'h204,      0, 1, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 32'hBAD0_0003, 0, 0, 32'h0,       0, 1, 0, 32'h204,      0, 1, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 32'hBAD0_0004, 0, 1, 32'h400,     0, 1, 0, 32'h204,      0, 1, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 32'h204,      0, 1, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hFFFF_FFFF, 0, 1, 1, 32'h0,       0, 1, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 32'h9999_FFFC, 0, 0, 32'h0,       0, 1, 1, 32'hFFFF_FFFC, 1, 0, 32'h9999_FFFC, 32'hFFFF_FFFC));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 1, 32'h0,        0, 1, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 1, 1, 32'h0,        0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 32'h6666_0000, 1, 0, 32'h0,       0, 1, 1, 32'h0,        0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 32'h4,        0, 1, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 32'h4,        0, 1, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 32'h4,        0, 1, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 32'h4444_0000, 0, 0, 32'h0,       0, 1, 1, 32'h0,        1, 0, 32'h4444_0000, 32'h0));

        foreach (vecs[i]) step(vecs[i], i);

        // Reset while an entry sits in the skid buffer must discard it.
        step(mk(0, 1, 32'h3333_0004, 1, 0, 32'h0, 0, 1, 1, 32'h4, 0, 0, 32'h0, 32'h0), 100);
        step(mk(1, 0, 32'h0,         0, 0, 32'h0, 0, 1, 0, 32'h8, 0, 1, 32'h0, 32'h0), 101);
        step(mk(0, 0, 32'h0,         0, 0, 32'h0, 0, 1, 1, 32'h0, 0, 1, 32'h0, 32'h0), 102);
        step(mk(0, 1, 32'h3333_0000, 0, 0, 32'h0, 0, 1, 1, 32'h0, 1, 0, 32'h3333_0000, 32'h0), 103);

        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
